// File: rtl/uart_bridge.sv
// Memory-mapped UART for the MMU's serial window: TX/RX byte FIFOs feeding
// 8N1 transmitter and receiver state machines on the board RS-232 pins.
package uart_bridge_pkg;
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;
endpackage

module uart_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  uartOp_i,
  input  logic [31:0] uart_storeData_i,
  output logic [31:0] uart_load_data_o,
  output logic        dataReady,
  output logic        writeReady,
  output logic        rx_overrun,
  output logic        frame_err,
  output logic        uart_txd,
  input  logic        uart_rxd
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BW  = $clog2(DIV);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(DIV / 2 - 1);

  logic is_store, is_load;
  assign is_store = uartOp_i inside {MEM_SB, MEM_SH, MEM_SW};
  assign is_load  = uartOp_i inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};

  // Only the low byte of a store reaches the line.
  logic unused_store_bits;
  assign unused_store_bits = ^uart_storeData_i[31:8];

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] tx_count, tx_count_d;
  logic          tx_push, tx_pop;

  assign tx_push = is_store && (tx_count < DEPTH_C);

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    tx_count_d = tx_count;
    if (tx_push && !tx_pop)      tx_count_d = tx_count + 1'b1;
    else if (!tx_push && tx_pop) tx_count_d = tx_count - 1'b1;
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count <= tx_count_d;
    end
  end

  // NOTE: storage is not reset; pointers and counts alone define valid entries.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= uart_storeData_i[7:0];
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] rx_count, rx_count_d;
  logic          rx_push, rx_pop;
  logic [7:0]    rx_shift;

  assign rx_pop = is_load && (rx_count != '0);
  assign uart_load_data_o = (rx_count != '0) ? {24'b0, rx_mem[rx_rd_ptr]} : 32'b0;

  always_comb begin
    rx_count_d = rx_count;
    if (rx_push && !rx_pop)      rx_count_d = rx_count + 1'b1;
    else if (!rx_push && rx_pop) rx_count_d = rx_count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count <= rx_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  // Status flags reflect post-edge occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataReady  <= 1'b0;
      writeReady <= 1'b1;
    end else begin
      dataReady  <= (rx_count_d != '0);
      writeReady <= (tx_count_d < DEPTH_C);
    end
  end

  // ---------------- Transmitter ----------------
  uart_state_e   tx_state, tx_state_d;
  logic [7:0]    tx_shift, tx_shift_d;
  logic [2:0]    tx_bit, tx_bit_d;
  logic [BW-1:0] tx_cnt, tx_cnt_d;
  logic          tx_txd_d;

  always_comb begin
    tx_state_d = tx_state;
    tx_shift_d = tx_shift;
    tx_bit_d   = tx_bit;
    tx_cnt_d   = tx_cnt;
    tx_pop     = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        if (tx_count != '0) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem[tx_rd_ptr];
          tx_cnt_d   = '0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end else tx_cnt_d = tx_cnt + 1'b1;
      end
      ST_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) tx_state_d = ST_STOP;
          else                tx_bit_d   = tx_bit + 1'b1;
        end else tx_cnt_d = tx_cnt + 1'b1;
      end
      ST_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
        end else tx_cnt_d = tx_cnt + 1'b1;
      end
      default: tx_state_d = ST_IDLE;
    endcase
    // The line is registered from the next state, so it changes with the state.
    case (tx_state_d)
      ST_START: tx_txd_d = 1'b0;
      ST_DATA:  tx_txd_d = tx_shift_d[0];
      default:  tx_txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= ST_IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_cnt   <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_shift <= tx_shift_d;
      tx_bit   <= tx_bit_d;
      tx_cnt   <= tx_cnt_d;
      uart_txd <= tx_txd_d;
    end
  end

  // ---------------- Receiver ----------------
  uart_state_e   rx_state, rx_state_d;
  logic [7:0]    rx_shift_d;
  logic [2:0]    rx_bit, rx_bit_d;
  logic [BW-1:0] rx_cnt, rx_cnt_d;
  logic          rx_s1, rx_s2, rx_s3;
  logic          set_overrun, set_ferr;

  always_comb begin
    rx_state_d  = rx_state;
    rx_shift_d  = rx_shift;
    rx_bit_d    = rx_bit;
    rx_cnt_d    = rx_cnt;
    rx_push     = 1'b0;
    set_overrun = 1'b0;
    set_ferr    = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (rx_s3 && !rx_s2) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        // Mid-start resample rejects glitches shorter than half a bit.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2 ? ST_IDLE : ST_DATA;
        end else rx_cnt_d = rx_cnt + 1'b1;
      end
      ST_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_d = ST_STOP;
          else                rx_bit_d   = rx_bit + 1'b1;
        end else rx_cnt_d = rx_cnt + 1'b1;
      end
      ST_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          if (!rx_s2)                   set_ferr    = 1'b1;
          else if (rx_count < DEPTH_C)  rx_push     = 1'b1;
          else                          set_overrun = 1'b1;
        end else rx_cnt_d = rx_cnt + 1'b1;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
      rx_state   <= ST_IDLE;
      rx_shift   <= '0;
      rx_bit     <= '0;
      rx_cnt     <= '0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= uart_rxd;
      rx_s2      <= rx_s1;
      rx_s3      <= rx_s2;
      rx_state   <= rx_state_d;
      rx_shift   <= rx_shift_d;
      rx_bit     <= rx_bit_d;
      rx_cnt     <= rx_cnt_d;
      rx_overrun <= rx_overrun | set_overrun;
      frame_err  <= frame_err | set_ferr;
    end
  end
endmodule

// File: tb/tb_uart_bridge.sv
// Directed bench for uart_bridge at DIV=16, DEPTH=4 with TX/RX scoreboards
// fed from the stimulus and drained when the DUT emits a frame or a read.
module tb_uart_bridge;
  import uart_bridge_pkg::*;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  uartOp_i;
  logic [31:0] uart_storeData_i;
  logic [31:0] uart_load_data_o;
  logic        dataReady, writeReady, rx_overrun, frame_err, uart_txd, uart_rxd;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];
  logic       exp_overrun = 1'b0;
  logic       exp_ferr    = 1'b0;

  uart_bridge #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .uartOp_i         (uartOp_i),
    .uart_storeData_i (uart_storeData_i),
    .uart_load_data_o (uart_load_data_o),
    .dataReady        (dataReady),
    .writeReady       (writeReady),
    .rx_overrun       (rx_overrun),
    .frame_err        (frame_err),
    .uart_txd         (uart_txd),
    .uart_rxd         (uart_rxd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_frame_bit(input int c, input logic [7:0] d);
    int idx;
    idx = c / DIV;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[idx-1];
  endfunction

  // Drive one 8N1 frame on rxd and update the RX scoreboard model.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      uart_rxd = 1'b0;
      else if (k == 9) uart_rxd = stop_bit;
      else             uart_rxd = b[k-1];
      repeat (DIV) step();
    end
    uart_rxd = 1'b1;
    if (!stop_bit)                 exp_ferr = 1'b1;
    else if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
    else                           exp_overrun = 1'b1;
  endtask

  task automatic do_store(input logic [31:0] d);
    uartOp_i = MEM_SB;
    uart_storeData_i = d;
    step();
    uartOp_i = MEM_NOP;
  endtask

  task automatic do_read(input string tag);
    logic [31:0] e;
    e = 32'h0;
    uartOp_i = MEM_LB;
    #1;
    if (rx_exp.size() != 0) e = {24'b0, rx_exp.pop_front()};
    check({tag, " data"}, uart_load_data_o, e);
    step();
    uartOp_i = MEM_NOP;
    check({tag, " dataReady"}, dataReady, rx_exp.size() != 0);
  endtask

  // Find the next start bit on txd, sample mid-bit, compare against the TX scoreboard.
  task automatic decode_tx(input string tag);
    logic [7:0]  got;
    logic [31:0] e;
    int n;
    n = 0;
    got = '0;
    while (uart_txd !== 1'b0 && n < 400) begin
      step();
      n++;
    end
    check({tag, " start seen"}, uart_txd, 0);
    repeat (DIV/2) step();
    check({tag, " start mid"}, uart_txd, 0);
    for (int k = 0; k < 8; k++) begin
      repeat (DIV) step();
      got[k] = uart_txd;
    end
    repeat (DIV) step();
    check({tag, " stop"}, uart_txd, 1);
    e = 32'h100;
    if (tx_exp.size() != 0) e = {24'b0, tx_exp.pop_front()};
    check({tag, " byte"}, {24'b0, got}, e);
  endtask

  initial begin
    int   tcnt;
    logic tidle, acc, pop, saw_low;

    rst = 1'b1;
    uartOp_i = MEM_NOP;
    uart_storeData_i = '0;
    uart_rxd = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset txd", uart_txd, 1);
    check("reset writeReady", writeReady, 1);
    check("reset dataReady", dataReady, 0);
    check("reset load_data", uart_load_data_o, 0);
    check("reset flags", {rx_overrun, frame_err}, 0);
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();

    // Single byte: exact per-cycle waveform, upper store bits ignored.
    do_store(32'h1A5);
    check("t2 txd before start", uart_txd, 1);
    for (int c = 0; c < 10*DIV; c++) begin
      step();
      check("t2 frame bit", uart_txd, exp_frame_bit(c, 8'hA5));
    end
    step();
    check("t2 idle after stop", uart_txd, 1);

    // Back-to-back stores into an idle transmitter; the 6th finds the FIFO full.
    tcnt  = 0;
    tidle = 1'b1;
    for (int i = 0; i < 6; i++) begin
      uartOp_i = MEM_SB;
      uart_storeData_i = 32'h11 + i;
      acc = (tcnt < DEPTH);
      pop = tidle && (tcnt > 0);
      step();
      if (acc) begin
        tx_exp.push_back(8'(8'h11 + i));
        tcnt++;
      end
      if (pop) begin
        tcnt--;
        tidle = 1'b0;
      end
      check("t3 writeReady", writeReady, tcnt < DEPTH);
    end
    uartOp_i = MEM_NOP;
    for (int f = 0; f < 5; f++) decode_tx("t3 frame");
    check("t3 scoreboard drained", tx_exp.size(), 0);
    saw_low = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (uart_txd !== 1'b1) saw_low = 1'b1;
    end
    check("t3 no dropped byte sent", saw_low, 0);
    check("t3 writeReady idle", writeReady, 1);

    // Receive one byte, read it, then read on empty.
    send_rx(8'hA3, 1'b1);
    check("t4 dataReady", dataReady, 1);
    do_read("t4 read");
    do_read("t4 empty read");

    // False start pulse, then a frame with a bad stop bit.
    uart_rxd = 1'b0;
    repeat (4) step();
    uart_rxd = 1'b1;
    repeat (3*DIV) step();
    check("t5 glitch dataReady", dataReady, 0);
    check("t5 glitch frame_err", frame_err, 0);
    send_rx(8'h5A, 1'b0);
    repeat (2) step();
    check("t5 frame_err", frame_err, exp_ferr);
    check("t5 no data", dataReady, 0);
    check("t5 overrun clear", rx_overrun, exp_overrun);

    // Five frames with no reads: the fifth overruns.
    for (int i = 0; i < 5; i++) begin
      send_rx(8'(8'h60 + i), 1'b1);
      check("t6 overrun", rx_overrun, exp_overrun);
    end
    check("t6 dataReady", dataReady, 1);
    for (int i = 0; i < 5; i++) do_read("t6 read");
    check("t6 frame_err sticky", frame_err, 1);

    // Asynchronous reset mid-frame with every status bit in its non-reset state.
    send_rx(8'h3C, 1'b1);
    for (int i = 0; i < 6; i++) begin
      uartOp_i = MEM_SB;
      uart_storeData_i = 32'h80 + i;
      step();
    end
    uartOp_i = MEM_NOP;
    check("t1 pre writeReady", writeReady, 0);
    check("t1 pre txd start", uart_txd, 0);
    check("t1 pre dataReady", dataReady, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t1 txd", uart_txd, 1);
    check("t1 writeReady", writeReady, 1);
    check("t1 dataReady", dataReady, 0);
    check("t1 rx_overrun", rx_overrun, 0);
    check("t1 frame_err", frame_err, 0);
    check("t1 load_data", uart_load_data_o, 0);
    tx_exp.delete();
    rx_exp.delete();
    exp_overrun = 1'b0;
    exp_ferr = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    repeat (2*DIV) step();
    check("t1 post txd idle", uart_txd, 1);
    tx_exp.push_back(8'h77);
    do_store(32'h77);
    decode_tx("t1 post frame");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
